// File: rtl/cache_line_filler_if.sv
// Cache refill bus: miss request from the cache, word reads to memory, completed line back.
interface cache_line_filler_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
);
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_ready;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data1;
  logic [DATA_W-1:0] fill_data2;
  logic [DATA_W-1:0] fill_data3;
  logic [DATA_W-1:0] fill_data4;
  logic              fill_err;
  logic              busy;

  // Cache/memory side.
  modport master (
    output miss_req, miss_addr, mem_rd_valid, mem_rd_data,
    input  miss_ready, mem_rd_en, mem_addr, fill_valid, fill_addr,
    input  fill_data1, fill_data2, fill_data3, fill_data4, fill_err, busy
  );

  // Filler side.
  modport slave (
    input  miss_req, miss_addr, mem_rd_valid, mem_rd_data,
    output miss_ready, mem_rd_en, mem_addr, fill_valid, fill_addr,
    output fill_data1, fill_data2, fill_data3, fill_data4, fill_err, busy
  );
endinterface

// File: rtl/cache_line_filler.sv
// Refill engine for a direct-mapped cache: fetches a 4-word line one word at a time,
// assembles it and reports completion or a per-word timeout abort.
module cache_line_filler #(
  parameter int unsigned ADDR_W  = 15,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic                clk,
  input logic                rst,
  cache_line_filler_if.slave bus
);

  localparam int unsigned LineW     = ADDR_W - 2;
  localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [1:0]        k_q, k_d, k_inc;
  logic [15:0]       timer_q, timer_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic              fill_valid_q, fill_valid_d;
  logic              fill_err_q, fill_err_d;
  logic [DATA_W-1:0] data_q [4];
  logic [DATA_W-1:0] data_d [4];
  logic              accept, sample_valid, timed_out;

  assign k_inc  = k_q + 2'd1;
  assign accept = (state_q == StIdle) && bus.miss_req;
  // Data arriving in the strobe cycle belongs to no outstanding read.
  assign sample_valid = (state_q == StWait) && bus.mem_rd_valid && !rd_en_q;
  assign timed_out    = (state_q == StWait) && !sample_valid && (timer_q == TimerLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      line_q       <= '0;
      k_q          <= '0;
      timer_q      <= '0;
      rd_en_q      <= 1'b0;
      mem_addr_q   <= '0;
      fill_addr_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      k_q          <= k_d;
      timer_q      <= timer_d;
      rd_en_q      <= rd_en_d;
      mem_addr_q   <= mem_addr_d;
      fill_addr_q  <= fill_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_err_q   <= fill_err_d;
      data_q       <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.miss_req) state_d = StWait;
      StWait: if ((sample_valid && k_q == 2'd3) || timed_out) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    line_d       = line_q;
    k_d          = k_q;
    timer_d      = timer_q;
    mem_addr_d   = mem_addr_q;
    fill_addr_d  = fill_addr_q;
    data_d       = data_q;
    rd_en_d      = 1'b0;
    fill_valid_d = 1'b0;
    fill_err_d   = 1'b0;
    if (accept) begin
      line_d     = bus.miss_addr[ADDR_W-1:2];
      k_d        = '0;
      timer_d    = '0;
      rd_en_d    = 1'b1;
      mem_addr_d = {bus.miss_addr[ADDR_W-1:2], 2'b00};
    end else if (state_q == StWait) begin
      if (sample_valid) begin
        data_d[k_q] = bus.mem_rd_data;
        timer_d     = '0;
        if (k_q == 2'd3) begin
          fill_valid_d = 1'b1;
          fill_addr_d  = {line_q, 2'b00};
        end else begin
          // Offset wraps within the line; never carries into the index.
          k_d        = k_inc;
          rd_en_d    = 1'b1;
          mem_addr_d = {line_q, k_inc};
        end
      end else begin
        timer_d = timer_q + 16'd1;
        if (timed_out) begin
          fill_err_d  = 1'b1;
          fill_addr_d = {line_q, 2'b00};
        end
      end
    end
  end

  assign bus.miss_ready = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.mem_rd_en  = rd_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_err   = fill_err_q;
  assign bus.fill_addr  = fill_addr_q;
  assign bus.fill_data1 = data_q[0];
  assign bus.fill_data2 = data_q[1];
  assign bus.fill_data3 = data_q[2];
  assign bus.fill_data4 = data_q[3];

endmodule

// File: tb/tb_cache_line_filler.sv
// Bench for cache_line_filler: reactive memory model, line scoreboard and directed/random fills.
module tb_cache_line_filler;

  localparam int unsigned Timeout = 8;

  logic        clk;
  logic        rst;
  int unsigned cyc;
  int unsigned n_tests;
  int unsigned n_fail;

  // Expected contents of the four line registers.
  logic [31:0] exp_regs [4];
  // Per-fill stimulus knobs.
  int          g_lat [4];
  int          g_drop;
  bit          g_junk;
  bit          g_hold;
  bit          g_fixed;
  logic [14:0] g_next;

  cache_line_filler_if #(.ADDR_W(15), .DATA_W(32)) bus ();

  cache_line_filler #(
    .ADDR_W (15),
    .DATA_W (32),
    .TIMEOUT(Timeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_data1"}, bus.fill_data1, exp_regs[0]);
    check({tag, "_data2"}, bus.fill_data2, exp_regs[1]);
    check({tag, "_data3"}, bus.fill_data3, exp_regs[2]);
    check({tag, "_data4"}, bus.fill_data4, exp_regs[3]);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    check({tag, "_fill_valid"}, 32'(bus.fill_valid), 0);
    check({tag, "_fill_err"}, 32'(bus.fill_err), 0);
    check({tag, "_fill_addr"}, 32'(bus.fill_addr), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check_regs(tag);
  endtask

  // Memory and RAM reads are never touched in idle; spurious valids must not change anything.
  task automatic idle_junk(input int n);
    for (int i = 0; i < n; i++) begin
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = $urandom;
      tick();
      check("idle_rd_en", 32'(bus.mem_rd_en), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_fill_valid", 32'(bus.fill_valid), 0);
    end
    bus.mem_rd_valid = 1'b0;
    tick();
    check_regs("idle");
  endtask

  // One line refill. With pre set, the request was already accepted and the bench sits in
  // the first strobe cycle.
  task automatic run_fill(input logic [14:0] addr, input bit pre);
    logic [14:0] base;
    logic [31:0] data;
    int          waited;
    int          early;
    base = addr & 15'h7FFC;
    if (!pre) begin
      check("ready_idle", 32'(bus.miss_ready), 1);
      bus.miss_req  = 1'b1;
      bus.miss_addr = addr;
      tick();
    end
    bus.miss_req  = g_hold;
    bus.miss_addr = g_hold ? g_next : 15'($urandom);
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      while (bus.mem_rd_en !== 1'b1 && waited < 20) begin
        tick();
        waited++;
      end
      check("strobe_delay", 32'(waited), 0);
      check("strobe_addr", 32'(bus.mem_addr), 32'(base) | 32'(k));
      check("busy_wait", 32'(bus.busy), 1);
      check("not_ready_wait", 32'(bus.miss_ready), 0);
      bus.mem_rd_valid = g_junk;
      bus.mem_rd_data  = $urandom;
      if (k == g_drop) begin
        early = 0;
        for (int i = 1; i < int'(Timeout); i++) begin
          tick();
          bus.mem_rd_valid = 1'b0;
          if (bus.fill_err || bus.fill_valid) early++;
        end
        tick();
        check("err_not_early", 32'(early), 0);
        check("err_pulse", 32'(bus.fill_err), 1);
        check("err_no_valid", 32'(bus.fill_valid), 0);
        check("err_addr", 32'(bus.fill_addr), 32'(base));
        check("err_ready", 32'(bus.miss_ready), 1);
        check_regs("err");
        tick();
        check("err_single", 32'(bus.fill_err), 0);
        check("err_ready_next", 32'(bus.miss_ready), 1);
        return;
      end
      for (int i = 0; i < g_lat[k]; i++) begin
        tick();
        bus.mem_rd_valid = 1'b0;
      end
      data             = g_fixed ? 32'(10 + 2 * k) : $urandom;
      bus.mem_rd_valid = 1'b1;
      bus.mem_rd_data  = data;
      exp_regs[k]      = data;
      if (k == 3) check("fill_not_early", 32'(bus.fill_valid), 0);
      tick();
      bus.mem_rd_valid = 1'b0;
    end
    check("fill_valid", 32'(bus.fill_valid), 1);
    check("fill_no_err", 32'(bus.fill_err), 0);
    check("fill_addr", 32'(bus.fill_addr), 32'(base));
    check("ready_on_pulse", 32'(bus.miss_ready), 1);
    check("rd_en_on_pulse", 32'(bus.mem_rd_en), 0);
    check_regs("fill");
    tick();
    check("fill_single", 32'(bus.fill_valid), 0);
    if (g_hold) begin
      bus.miss_req = 1'b0;
      check("b2b_strobe", 32'(bus.mem_rd_en), 1);
      check("b2b_addr", 32'(bus.mem_addr), 32'(g_next & 15'h7FFC));
    end else begin
      check("ready_after", 32'(bus.miss_ready), 1);
    end
  endtask

  initial begin
    bit          pre;
    logic [14:0] addr;
    cyc              = 0;
    n_tests          = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.miss_req     = 1'b0;
    bus.miss_addr    = '0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    for (int i = 0; i < 4; i++) g_lat[i] = 1;
    g_drop  = 4;
    g_junk  = 1'b0;
    g_hold  = 1'b0;
    g_fixed = 1'b0;
    g_next  = '0;

    #1 rst = 1'b0;
    #2;
    check_reset("rst_init");
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("ready_after_rst", 32'(bus.miss_ready), 1);

    // 1-cycle memory, fixed data, unaligned request.
    g_fixed = 1'b1;
    run_fill(15'h0005, 1'b0);
    g_fixed = 1'b0;

    // 3-cycle memory at the top of the address space.
    for (int i = 0; i < 4; i++) g_lat[i] = 3;
    run_fill(15'h7FFC, 1'b0);

    // Memory never answers word 2.
    for (int i = 0; i < 4; i++) g_lat[i] = 1;
    g_drop = 2;
    run_fill(15'h1234, 1'b0);
    g_drop = 4;

    // Request held through the pulse: back-to-back accept.
    g_hold = 1'b1;
    g_next = 15'h0100;
    run_fill(15'h2468, 1'b0);
    g_hold = 1'b0;
    run_fill(15'h0100, 1'b1);

    // Spurious valids in idle and coincident with the strobe.
    idle_junk(3);
    g_junk = 1'b1;
    run_fill(15'h4321, 1'b0);
    g_junk = 1'b0;

    // Reset in the middle of a fill.
    bus.miss_req  = 1'b1;
    bus.miss_addr = 15'($urandom);
    tick();
    bus.miss_req = 1'b0;
    tick();
    bus.mem_rd_valid = 1'b1;
    bus.mem_rd_data  = $urandom;
    tick();
    bus.mem_rd_valid = 1'b0;
    check("mid_busy", 32'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) exp_regs[i] = '0;
    check_reset("rst_mid");
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_ready", 32'(bus.miss_ready), 1);
      check("post_rst_no_valid", 32'(bus.fill_valid), 0);
      check("post_rst_no_err", 32'(bus.fill_err), 0);
      check("post_rst_rd_en", 32'(bus.mem_rd_en), 0);
    end

    // Randomized fills.
    pre  = 1'b0;
    addr = 15'($urandom);
    for (int it = 0; it < 24; it++) begin
      for (int k = 0; k < 4; k++) g_lat[k] = int'($urandom_range(1, Timeout - 1));
      g_junk = bit'($urandom_range(0, 1));
      g_drop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : 4;
      g_hold = (g_drop == 4) && (it != 23) && ($urandom_range(0, 2) == 0);
      g_next = 15'($urandom);
      if (!pre && $urandom_range(0, 1) == 1) idle_junk(int'($urandom_range(1, 3)));
      run_fill(addr, pre);
      pre  = g_hold;
      addr = g_hold ? g_next : 15'($urandom);
    end
    g_hold = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
